// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a 128x16 synchronous data memory.
// Define DMEM_ARB_FIXED_PRIO_EN to make port A always win ties (round-robin pointer removed).
module dmem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              a_err,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state, state_next;
    logic              a_elig, b_elig, grant, pick_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we, sel_oor;

    logic              a_gnt_next, b_gnt_next, a_err_next, b_err_next;
    logic              mem_write_next, mem_read_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next;
    logic              slot_rd_next, slot_b_next, slot_err_next;

    // Slot bookkeeping travels one stage behind the memory enables to steer rvalid.
    logic              slot_rd, slot_b, slot_err;
    logic              ret_zero;
    logic [DATA_W-1:0] a_rdata_hold, b_rdata_hold, ret_data;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              last_b;
`endif

    assign a_elig = a_req & ~a_gnt;
    assign b_elig = b_req & ~b_gnt;
    assign grant  = a_elig | b_elig;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign pick_b = b_elig & ~a_elig;
`else
    assign pick_b = b_elig & (~a_elig | ~last_b);
`endif

    assign sel_addr  = pick_b ? b_addr  : a_addr;
    assign sel_wdata = pick_b ? b_wdata : a_wdata;
    assign sel_we    = pick_b ? b_we    : a_we;
    assign sel_oor   = {1'b0, sel_addr} >= DEPTH_LIMIT;

    always_comb begin
        state_next     = state;
        a_gnt_next     = 1'b0;
        b_gnt_next     = 1'b0;
        a_err_next     = 1'b0;
        b_err_next     = 1'b0;
        mem_write_next = 1'b0;
        mem_read_next  = 1'b0;
        mem_addr_next  = mem_addr;
        mem_wdata_next = mem_wdata;
        slot_rd_next   = 1'b0;
        slot_b_next    = 1'b0;
        slot_err_next  = 1'b0;

        case (state)
            IDLE:    state_next = grant ? ISSUE : IDLE;
            ISSUE:   state_next = grant ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase

        if (grant) begin
            a_gnt_next     = ~pick_b;
            b_gnt_next     = pick_b;
            a_err_next     = sel_oor & ~pick_b;
            b_err_next     = sel_oor & pick_b;
            mem_write_next = sel_we & ~sel_oor;
            mem_read_next  = ~sel_we & ~sel_oor;
            mem_addr_next  = sel_addr;
            mem_wdata_next = sel_wdata;
            slot_rd_next   = ~sel_we;
            slot_b_next    = pick_b;
            slot_err_next  = sel_oor;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_err     <= 1'b0;
            b_err     <= 1'b0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            slot_rd   <= 1'b0;
            slot_b    <= 1'b0;
            slot_err  <= 1'b0;
        end else begin
            state     <= state_next;
            a_gnt     <= a_gnt_next;
            b_gnt     <= b_gnt_next;
            a_err     <= a_err_next;
            b_err     <= b_err_next;
            mem_write <= mem_write_next;
            mem_read  <= mem_read_next;
            mem_addr  <= mem_addr_next;
            mem_wdata <= mem_wdata_next;
            slot_rd   <= slot_rd_next;
            slot_b    <= slot_b_next;
            slot_err  <= slot_err_next;
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Pointer starts as "B last" so A takes the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b <= 1'b1;
        end else if (grant) begin
            last_b <= pick_b;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            ret_zero <= 1'b0;
        end else begin
            a_rvalid <= slot_rd & ~slot_b;
            b_rvalid <= slot_rd & slot_b;
            ret_zero <= slot_err;
        end
    end

    // Return data passes straight through during rvalid, then is held per port.
    assign ret_data = ret_zero ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rdata_hold <= '0;
            b_rdata_hold <= '0;
        end else begin
            if (a_rvalid) a_rdata_hold <= ret_data;
            if (b_rvalid) b_rdata_hold <= ret_data;
        end
    end

    assign a_rdata = a_rvalid ? ret_data : a_rdata_hold;
    assign b_rdata = b_rvalid ? ret_data : b_rdata_hold;

endmodule
